// File: rtl/uart_io_pkg.sv
// Shared UART register map, STATUS bit positions and FSM state encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
package uart_io_pkg;

  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_RXDATA  = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_BAUDDIV = 2'd3;

  localparam int ST_TX_BUSY   = 0;
  localparam int ST_RX_VALID  = 1;
  localparam int ST_OVERRUN   = 2;
  localparam int ST_FRAME_ERR = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_io_rx.sv
// UART receiver: synchroniser, start-bit glitch filter, 8N1 mid-bit sampling.
// Latency: byte/done/frame_err pulse one clock after the stop-bit sample. Backpressure: none.
module uart_io_rx
  import uart_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rxd_i,
  input  logic [15:0] div_i,
  output logic [7:0]  byte_o,
  output logic        done_o,
  output logic        frame_err_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   prev_q;
  uart_state_e            state_q;
  logic [15:0]            cnt_q;
  logic [2:0]             bit_q;
  logic [7:0]             shreg_q;
  logic [7:0]             byte_q;
  logic                   done_q;
  logic                   ferr_q;
  logic [15:0]            half;
  logic [15:0]            half_m1;
  logic [15:0]            div_m1;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign half    = ((div_i >> 1) == 16'd0) ? 16'd1 : (div_i >> 1);
  assign half_m1 = half - 16'd1;
  assign div_m1  = div_i - 16'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q <= SYNC_STAGES'({sync_q, rxd_i});
      prev_q <= rx_s;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (prev_q && !rx_s) begin
            state_q <= ST_START;
            cnt_q   <= half_m1;
          end
        end
        ST_START: begin
          if (cnt_q == 16'd0) begin
            // A line already back high at mid-start is treated as noise.
            state_q <= rx_s ? ST_IDLE : ST_DATA;
            cnt_q   <= div_m1;
            bit_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (cnt_q == 16'd0) begin
            shreg_q <= {rx_s, shreg_q[7:1]};
            cnt_q   <= div_m1;
            if (bit_q == 3'd7) state_q <= ST_STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (cnt_q == 16'd0) begin
            byte_q  <= shreg_q;
            done_q  <= 1'b1;
            ferr_q  <= ~rx_s;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign byte_o      = byte_q;
  assign done_o      = done_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_io.sv
// Memory-mapped 8N1 UART: bus register file, TX FSM, instantiated RX path.
// Latency: writes act on the strobe edge, reads are combinational. Backpressure: TXDATA writes while busy are dropped.
module uart_io
  import uart_io_pkg::*;
#(
  parameter int DIV_RESET   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);

  logic [1:0]  sel;
  logic        wr_en, rd_en, wr_tx, rd_rx;
  logic [15:0] baud_q, baud_d;
  logic [15:0] div_eff, div_m1;
  logic [7:0]  rxdata_q, rxdata_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic        ferr_q, ferr_d;
  logic [7:0]  rx_byte;
  logic        rx_done, rx_ferr;
  uart_state_e tx_state_q;
  logic [15:0] tx_cnt_q;
  logic [2:0]  tx_bit_q;
  logic [7:0]  tx_sh_q;
  logic        txd_q;
  logic        tx_busy;
  logic [3:0]  status;
  logic        unused_bits;

  assign sel         = addr[3:2];
  assign wr_en       = ce & we;
  assign rd_en       = ce & ~we;
  assign wr_tx       = wr_en && (sel == ADDR_TXDATA);
  assign rd_rx       = rd_en && (sel == ADDR_RXDATA);
  assign div_eff     = (baud_q == 16'd0) ? 16'd1 : baud_q;
  assign div_m1      = div_eff - 16'd1;
  assign tx_busy     = (tx_state_q != ST_IDLE);
  assign unused_bits = ^{addr[31:4], addr[1:0], dataIn[31:16]};

  uart_io_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk_i       (clk),
    .rst_ni      (rst),
    .rxd_i       (rxd),
    .div_i       (div_eff),
    .byte_o      (rx_byte),
    .done_o      (rx_done),
    .frame_err_o (rx_ferr)
  );

  always_comb begin
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    ferr_d     = ferr_q;
    rxdata_d   = rxdata_q;
    baud_d     = baud_q;
    if (wr_en && sel == ADDR_STATUS) begin
      if (dataIn[ST_OVERRUN])   overrun_d = 1'b0;
      if (dataIn[ST_FRAME_ERR]) ferr_d    = 1'b0;
    end
    if (wr_en && sel == ADDR_BAUDDIV) baud_d = dataIn[15:0];
    if (rd_rx) rx_valid_d = 1'b0;
    // Hardware events come last so they win over software clears.
    if (rx_done) begin
      rxdata_d   = rx_byte;
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rd_rx) overrun_d = 1'b1;
      if (rx_ferr)              ferr_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_q     <= 16'(DIV_RESET);
      rxdata_q   <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      baud_q     <= baud_d;
      rxdata_q   <= rxdata_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      ferr_q     <= ferr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      case (tx_state_q)
        ST_IDLE: begin
          if (wr_tx) begin
            tx_sh_q    <= dataIn[7:0];
            txd_q      <= 1'b0;
            tx_cnt_q   <= div_m1;
            tx_state_q <= ST_START;
          end
        end
        ST_START: begin
          if (tx_cnt_q == 16'd0) begin
            txd_q      <= tx_sh_q[0];
            tx_sh_q    <= tx_sh_q >> 1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= div_m1;
            tx_state_q <= ST_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (tx_cnt_q == 16'd0) begin
            tx_cnt_q <= div_m1;
            if (tx_bit_q == 3'd7) begin
              txd_q      <= 1'b1;
              tx_state_q <= ST_STOP;
            end else begin
              txd_q    <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
              tx_bit_q <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (tx_cnt_q == 16'd0) tx_state_q <= ST_IDLE;
          else                   tx_cnt_q   <= tx_cnt_q - 16'd1;
        end
        default: tx_state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    status               = '0;
    status[ST_TX_BUSY]   = tx_busy;
    status[ST_RX_VALID]  = rx_valid_q;
    status[ST_OVERRUN]   = overrun_q;
    status[ST_FRAME_ERR] = ferr_q;
  end

  always_comb begin
    dataOut = '0;
    if (rd_en) begin
      case (sel)
        ADDR_RXDATA:  dataOut = {24'd0, rxdata_q};
        ADDR_STATUS:  dataOut = {28'd0, status};
        ADDR_BAUDDIV: dataOut = {16'd0, baud_q};
        default:      dataOut = '0;
      endcase
    end
  end

  assign txd = txd_q;
  assign irq = rx_valid_q;

endmodule

// File: tb/tb_uart_io.sv
// Scoreboard bench for uart_io: TX bits decoded off txd, RX bytes checked via RXDATA.
module tb_uart_io;

  localparam logic [31:0] A_TX = 32'h0;
  localparam logic [31:0] A_RX = 32'h4;
  localparam logic [31:0] A_ST = 32'h8;
  localparam logic [31:0] A_BD = 32'hC;

  logic        clk = 1'b0;
  logic        rst, ce, we, rxd;
  logic [31:0] addr, dataIn, dataOut;
  logic        txd, irq;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   tb_div   = 4;
  bit   mon_en   = 1'b0;
  logic       tx_q[$];
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_io #(.DIV_RESET(16), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .we      (we),
    .addr    (addr),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .rxd     (rxd),
    .txd     (txd),
    .irq     (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    ce = 1'b1; we = 1'b1; addr = a; dataIn = d;
    tick(1);
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = a;
    #1 d = dataOut;
    tick(1);
    ce = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    ce = 1'b1; we = 1'b0; addr = a;
    #1 d = dataOut;
    ce = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_q.push_back(b[i]);
    tx_q.push_back(1'b1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0; tick(tb_div);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i]; tick(tb_div);
    end
    rxd = stop_bit; tick(tb_div);
    rxd = 1'b1; tick(2 * tb_div);
  endtask

  task automatic read_rx_check(input string tag);
    logic [31:0] d;
    logic [7:0]  exp;
    exp = rx_q[$];
    rx_q.delete();
    bus_rd(A_RX, d);
    check(tag, d, {24'd0, exp});
  endtask

  task automatic wait_tx_idle(input int bound);
    logic [31:0] d;
    d = 32'h1;
    for (int i = 0; i < bound; i++) begin
      peek(A_ST, d);
      if (!d[0]) break;
      tick(1);
    end
    check("tx_idle", {31'd0, d[0]}, 32'd0);
  endtask

  task automatic wait_irq(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (irq) break;
      tick(1);
    end
    check("irq_set", {31'd0, irq}, 32'd1);
  endtask

  // Decodes each frame seen on txd at mid-bit against the expected bit queue.
  initial begin
    forever begin
      @(negedge txd);
      if (mon_en) begin
        if (tx_q.size() == 0) begin
          check("tx_unexpected_frame", tx_q.size(), 32'd1);
        end else begin
          repeat (tb_div / 2) @(posedge clk);
          #1;
          for (int i = 0; i < 10; i++) begin
            if (tx_q.size() > 0)
              check($sformatf("tx_bit%0d", i), {31'd0, txd}, {31'd0, tx_q.pop_front()});
            if (i < 9) begin
              repeat (tb_div) @(posedge clk);
              #1;
            end
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] d;
    int busy;
    rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; dataIn = '0; rxd = 1'b1;
    tick(3);
    check("rst_txd", {31'd0, txd}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    peek(A_ST, d); check("rst_status", d, 32'h0); tick(1);
    peek(A_RX, d); check("rst_rxdata", d, 32'h0); tick(1);
    peek(A_BD, d); check("rst_bauddiv", d, 32'd16); tick(1);

    rst = 1'b1;
    bus_wr(A_BD, 32'd4);
    tb_div = 4;
    peek(A_BD, d); check("first_access_bauddiv", d, 32'd4); tick(1);

    mon_en = 1'b1;
    push_tx(8'hA5);
    bus_wr(A_TX, 32'hA5);
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      peek(A_ST, d);
      if (!d[0]) break;
      busy++;
      tick(1);
    end
    check("tx_busy_cycles", busy, 32'd40);
    tick(5);
    check("tx_a5_drained", tx_q.size(), 32'd0);

    push_tx(8'hA5);
    bus_wr(A_TX, 32'hA5);
    tick(9);
    bus_wr(A_TX, 32'h3C);
    wait_tx_idle(200);
    tick(60);
    check("tx_ignored_write_drained", tx_q.size(), 32'd0);
    peek(A_ST, d); check("tx_ignored_no_flag", d, 32'h0); tick(1);

    bus_wr(A_BD, 32'd8);
    tb_div = 8;
    rx_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b1);
    wait_irq(64);
    bus_rd(A_ST, d); check("rx_status_valid", d, 32'h2);
    bus_rd(A_ST, d); check("rx_status_read_no_side_effect", d, 32'h2);
    read_rx_check("rx_byte_5a");
    peek(A_ST, d); check("rx_valid_cleared", d, 32'h0); tick(1);
    check("irq_cleared", {31'd0, irq}, 32'd0);

    rx_q.push_back(8'h11);
    send_rx(8'h11, 1'b1);
    rx_q.push_back(8'h22);
    send_rx(8'h22, 1'b1);
    peek(A_ST, d); check("rx_overrun_status", d, 32'h6); tick(1);
    bus_wr(A_ST, 32'h4);
    peek(A_ST, d); check("rx_overrun_w1c", d, 32'h2); tick(1);
    read_rx_check("rx_byte_overwrite");

    rxd = 1'b0; tick(2);
    rxd = 1'b1; tick(40);
    check("glitch_no_irq", {31'd0, irq}, 32'd0);
    peek(A_ST, d); check("glitch_status", d, 32'h0); tick(1);

    rx_q.push_back(8'h96);
    send_rx(8'h96, 1'b0);
    wait_irq(64);
    peek(A_ST, d); check("frame_err_status", d, 32'hA); tick(1);
    read_rx_check("frame_err_byte");
    bus_wr(A_ST, 32'h8);
    peek(A_ST, d); check("frame_err_w1c", d, 32'h0); tick(1);

    bus_wr(A_BD, 32'd4);
    tb_div = 4;
    mon_en = 1'b0;
    bus_wr(A_TX, 32'h00);
    tick(20);
    check("tx_bit4_low", {31'd0, txd}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid_frame_txd", {31'd0, txd}, 32'd1);
    peek(A_ST, d); check("rst_mid_frame_status", d, 32'h0);
    tick(2);
    rst = 1'b1;
    bus_wr(A_BD, 32'd4);
    mon_en = 1'b1;
    push_tx(8'hC3);
    bus_wr(A_TX, 32'hC3);
    wait_tx_idle(200);
    tick(5);
    check("tx_after_reset_drained", tx_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
